// File: rtl/toggle_cover_sched.sv
// Toggle-coverage event scheduler: sticky pending set of toggle hits, serialized
// round-robin into one cover index per handshake, with first-hit dedup and drain.
module toggle_cover_sched #(
    parameter int WIDTH       = 39,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 11747,
    parameter int DEDUP       = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           valid,
    input  logic                       enable,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_index,
    input  logic                       flush,
    output logic                       flush_done,
    input  logic                       clear,
    output logic [$clog2(WIDTH+1)-1:0] pending_cnt,
    output logic [31:0]                drop_cnt
);

    localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(WIDTH+1);

    if (WIDTH < 1 || WIDTH > 1024 || COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_param_chk
        $error("toggle_cover_sched: WIDTH/COVER_INDEX out of range");
    end

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DRAINED} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [WIDTH-1:0]   seen_q, seen_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [63:0]        out_index_q, out_index_d;
    logic               flush_done_q, flush_done_d;
    logic [CNT_W-1:0]   pending_cnt_q, pending_cnt_d;
    logic [31:0]        drop_cnt_q, drop_cnt_d;

    logic               found, slot_free, issue, cap_en, drop_hit;
    logic [PTR_W-1:0]   sel;
    logic [WIDTH-1:0]   issue_mask, eligible, cap;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= WIDTH) s = s - WIDTH;
        return PTR_W'(s);
    endfunction

    // Round-robin pick: first pending bit at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (!found && pending_q[wrap_add(ptr_q, k)]) begin
                found = 1'b1;
                sel   = wrap_add(ptr_q, k);
            end
        end
    end

    always_comb begin
        slot_free  = !out_valid_q || out_ready;
        issue      = slot_free && found;
        issue_mask = '0;
        if (issue) issue_mask[sel] = 1'b1;

        cap_en   = (state_q == ST_RUN) && enable;
        eligible = cap_en ? valid : '0;
        if (DEDUP != 0) begin
            // A hit on the bit issued this cycle is already covered: suppress it.
            cap      = eligible & ~seen_q & ~issue_mask;
            drop_hit = |(eligible & (pending_q | seen_q));
        end else begin
            cap      = eligible;
            drop_hit = |(eligible & pending_q & ~issue_mask);
        end

        pending_d = (pending_q & ~issue_mask) | cap;

        seen_d = seen_q;
        if (DEDUP != 0) seen_d = seen_q | issue_mask;
        if (clear) seen_d = '0;

        ptr_d       = issue ? wrap_add(sel, 1) : ptr_q;
        out_valid_d = slot_free ? issue : out_valid_q;
        out_index_d = issue ? 64'(COVER_INDEX) + 64'(sel) : out_index_q;

        drop_cnt_d = drop_cnt_q;
        if (drop_hit && drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_q + 32'd1;

        pending_cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) pending_cnt_d = pending_cnt_d + CNT_W'(pending_d[i]);

        state_d = state_q;
        case (state_q)
            ST_RUN:     if (flush) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!flush) state_d = ST_RUN;
                else if (pending_q == '0 && !out_valid_q) state_d = ST_DRAINED;
            end
            ST_DRAINED: if (!flush) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
        flush_done_d = (state_d == ST_DRAINED);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pending_q     <= '0;
            seen_q        <= '0;
            ptr_q         <= '0;
            out_valid_q   <= 1'b0;
            out_index_q   <= '0;
            flush_done_q  <= 1'b0;
            pending_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            seen_q        <= seen_d;
            ptr_q         <= ptr_d;
            out_valid_q   <= out_valid_d;
            out_index_q   <= out_index_d;
            flush_done_q  <= flush_done_d;
            pending_cnt_q <= pending_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_index   = out_index_q;
    assign flush_done  = flush_done_q;
    assign pending_cnt = pending_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule
